pfxsum_serializer: RTL and testbench

- Downstream neighbour of the prefix-sum stage. Consumes each completed result vector (valid_in/ivec, one-cycle strobe).
- Buffers up to DEPTH vectors and streams them out one integer per cycle over a valid/ready interface, tagged with element index and last flag.
- Decouples the vector-wide scan engine from narrow consumers (UART/host FIFO). Detects and flags vectors dropped while the buffer is full.

---
 rtl/pfxsum_serializer.sv | 117 +++++++++++
 tb/tb_pfxsum_serializer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/pfxsum_serializer.sv
// Buffers whole prefix-sum result vectors and streams them out one element per cycle
// over valid/ready, tagging each element with its index and a last flag.
module pfxsum_serializer #(
    parameter int INT_WIDTH = 32,
    parameter int V_LEN     = 16,
    parameter int DEPTH     = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           valid_in,
    input  logic [V_LEN*INT_WIDTH-1:0]     ivec,
    output logic                           in_ready,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [INT_WIDTH-1:0]           out_data,
    output logic [$clog2(V_LEN)-1:0]       out_idx,
    output logic                           out_last,
    output logic [$clog2(DEPTH):0]         vec_count,
    output logic                           overflow
);

    localparam int IDX_W = $clog2(V_LEN);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(V_LEN - 1);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t                       state;
    logic [V_LEN*INT_WIDTH-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]             wr_ptr;
    logic [PTR_W-1:0]             rd_ptr;
    logic                         push;
    logic                         pop;
    logic [CNT_W-1:0]             cnt_next;
    logic [V_LEN*INT_WIDTH-1:0]   cur_vec;
    logic [INT_WIDTH-1:0]         elem [V_LEN];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Admission is purely count-based, so a same-cycle pop never raises in_ready.
    assign in_ready = (vec_count < CNT_W'(DEPTH));
    assign push     = valid_in && in_ready;
    assign pop      = (state == STREAM) && out_ready && (out_idx == LAST_IDX);
    assign cnt_next = vec_count + CNT_W'(push) - CNT_W'(pop);

    // Vector storage carries no reset; occupancy is tracked by the control state.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= ivec;
        end
    end

    assign cur_vec = mem[rd_ptr];

    for (genvar k = 0; k < V_LEN; k++) begin : g_unpack
        assign elem[k] = cur_vec[k*INT_WIDTH +: INT_WIDTH];
    end

    assign out_data = elem[out_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            vec_count <= '0;
            overflow  <= 1'b0;
        end else begin
            if (valid_in && !in_ready) begin
                overflow <= 1'b1;
            end
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            vec_count <= cnt_next;

            case (state)
                IDLE: begin
                    if (vec_count != '0) begin
                        state     <= STREAM;
                        out_valid <= 1'b1;
                        out_idx   <= '0;
                        out_last  <= 1'b0;
                    end
                end
                STREAM: begin
                    if (out_ready) begin
                        if (out_idx == LAST_IDX) begin
                            // Next buffered vector (possibly pushed this cycle) follows without a bubble.
                            rd_ptr   <= ptr_inc(rd_ptr);
                            out_idx  <= '0;
                            out_last <= 1'b0;
                            if (cnt_next == '0) begin
                                state     <= IDLE;
                                out_valid <= 1'b0;
                            end
                        end else begin
                            out_idx  <= out_idx + IDX_W'(1);
                            out_last <= (out_idx == LAST_IDX - IDX_W'(1));
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pfxsum_serializer.sv
// Scoreboard bench for pfxsum_serializer: a negedge monitor models occupancy, overflow
// and out_valid, and compares every presented beat against the expected queue.
module tb_pfxsum_serializer;

    localparam int INT_WIDTH = 32;
    localparam int V_LEN     = 16;
    localparam int DEPTH     = 2;
    localparam int VW        = V_LEN * INT_WIDTH;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     valid_in = 1'b0;
    logic [VW-1:0]            ivec = '0;
    logic                     in_ready;
    logic                     out_valid;
    logic                     out_ready = 1'b0;
    logic [INT_WIDTH-1:0]     out_data;
    logic [$clog2(V_LEN)-1:0] out_idx;
    logic                     out_last;
    logic [$clog2(DEPTH):0]   vec_count;
    logic                     overflow;

    pfxsum_serializer #(.INT_WIDTH(INT_WIDTH), .V_LEN(V_LEN), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .ivec(ivec), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_idx(out_idx), .out_last(out_last), .vec_count(vec_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [INT_WIDTH-1:0] d;
        logic [3:0]           i;
        logic                 l;
    } beat_t;

    beat_t q[$];
    int    n_cmp = 0;
    int    n_err = 0;
    int    mcount = 0;
    logic  mover = 1'b0;
    logic  mvalid = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    // Reference model: evaluated mid-cycle, when inputs and DUT outputs are settled.
    always @(negedge clk) begin
        beat_t e;
        logic  acc;
        logic  pop;
        int    old_cnt;
        if (rst) begin
            mcount = 0;
            mover  = 1'b0;
            mvalid = 1'b0;
            q.delete();
        end else begin
            chk("out_valid", 64'(out_valid), 64'(mvalid));
            chk("in_ready", 64'(in_ready), 64'(mcount < DEPTH));
            chk("vec_count", 64'(vec_count), 64'(mcount));
            chk("overflow", 64'(overflow), 64'(mover));
            pop = 1'b0;
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("beat_expected", 64'(q.size()), 64'd1);
                end else begin
                    e = q[0];
                    chk("out_data", 64'(out_data), 64'(e.d));
                    chk("out_idx", 64'(out_idx), 64'(e.i));
                    chk("out_last", 64'(out_last), 64'(e.l));
                    if (out_ready) begin
                        void'(q.pop_front());
                        pop = e.l;
                    end
                end
            end
            acc = valid_in && (mcount < DEPTH);
            if (valid_in && !acc) mover = 1'b1;
            if (acc) begin
                for (int k = 0; k < V_LEN; k++) begin
                    e.d = ivec[k*INT_WIDTH +: INT_WIDTH];
                    e.i = 4'(k);
                    e.l = (k == V_LEN - 1);
                    q.push_back(e);
                end
            end
            old_cnt = mcount;
            mcount  = mcount + int'(acc) - int'(pop);
            mvalid  = mvalid ? (mcount != 0) : (old_cnt != 0);
        end
    end

    // All stimulus changes happen 1 time unit after a rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_vec(input logic [VW-1:0] v);
        valid_in = 1'b1;
        ivec     = v;
        step();
        valid_in = 1'b0;
    endtask

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        for (int k = 0; k < V_LEN; k++) v[k*INT_WIDTH +: INT_WIDTH] = $urandom;
        return v;
    endfunction

    task automatic drain(input int max_cycles, input int pattern);
        int c;
        c = 0;
        while ((q.size() != 0 || out_valid) && c < max_cycles) begin
            out_ready = (pattern == 0) ? 1'b1 : ((c % 3) == 0);
            step();
            c++;
        end
        out_ready = 1'b1;
        if (c >= max_cycles) chk("drain_timeout", 64'(q.size()), 64'd0);
    endtask

    task automatic wait_idx(input int idx, output logic hit);
        hit = 1'b0;
        for (int c = 0; c < 200 && !hit; c++) begin
            if (out_valid && out_idx == 4'(idx)) hit = 1'b1;
            else step();
        end
        if (!hit) chk("wait_idx_timeout", 64'(out_idx), 64'(idx));
    endtask

    initial begin
        logic [VW-1:0] v;
        logic          hit;

        // Reset held with valid_in high: nothing may be stored.
        rst = 1'b1;
        valid_in = 1'b1;
        ivec = rand_vec();
        step();
        step();
        rst = 1'b0;
        valid_in = 1'b0;
        step();
        chk("rst_out_idx", 64'(out_idx), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        chk("rst_vec_count", 64'(vec_count), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        repeat (3) step();

        // Single vector, element k = 3k, consumer always ready.
        for (int k = 0; k < V_LEN; k++) v[k*INT_WIDTH +: INT_WIDTH] = 32'(3 * k);
        out_ready = 1'b1;
        push_vec(v);
        drain(100, 0);
        step();

        // Same vector under backpressure 1,0,0 pattern.
        out_ready = 1'b0;
        push_vec(v);
        drain(200, 1);
        step();

        // Overflow: three pushes with the consumer stalled; third is dropped.
        out_ready = 1'b0;
        push_vec(rand_vec());
        push_vec(rand_vec());
        chk("full_in_ready", 64'(in_ready), 64'd0);
        push_vec(rand_vec());
        chk("overflow_set", 64'(overflow), 64'd1);
        drain(200, 0);
        step();

        // Push coinciding with the final handshake of the current vector.
        out_ready = 1'b1;
        push_vec(rand_vec());
        wait_idx(V_LEN - 1, hit);
        valid_in = 1'b1;
        ivec = rand_vec();
        step();
        valid_in = 1'b0;
        chk("simul_vec_count", 64'(vec_count), 64'd1);
        chk("simul_out_idx", 64'(out_idx), 64'd0);
        drain(100, 0);
        step();

        // Reset mid-stream at element 7 with another vector buffered.
        out_ready = 1'b1;
        push_vec(rand_vec());
        push_vec(rand_vec());
        wait_idx(7, hit);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_vec_count", 64'(vec_count), 64'd0);
        chk("midrst_overflow", 64'(overflow), 64'd0);
        push_vec(rand_vec());
        drain(100, 0);
        repeat (2) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
